// File: rtl/pcore_config_defs.sv
// Shared types for the execute-to-divider path: request/response structs, op codes, FSM states.
package pcore_config_defs;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = 5;

    typedef enum logic [2:0] {
        ALU_D_OPS_NONE = 3'd0,
        ALU_D_OPS_DIV  = 3'd1,
        ALU_D_OPS_DIVU = 3'd2,
        ALU_D_OPS_REM  = 3'd3,
        ALU_D_OPS_REMU = 3'd4
    } type_alu_d_ops_e;

    typedef struct packed {
        type_alu_d_ops_e alu_d_ops;
        logic [XLEN-1:0] opr1;
        logic [XLEN-1:0] opr2;
    } type_exe2div_s;

    typedef struct packed {
        logic [XLEN-1:0] alu_result;
        logic            div_done;
    } type_div2wrb_s;

    typedef struct packed {
        logic div_busy;
    } type_div2fwd_s;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } type_div_state_e;

    function automatic logic [XLEN-1:0] abs_val(input logic [XLEN-1:0] v);
        return v[XLEN-1] ? (~v + 1'b1) : v;
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift {rem, quo} left, trial-subtract the divisor.
module div_step
    import pcore_config_defs::*;
(
    input  logic [XLEN-1:0] rem_i,
    input  logic [XLEN-1:0] quo_i,
    input  logic [XLEN-1:0] dvs_i,
    output logic [XLEN-1:0] rem_o,
    output logic [XLEN-1:0] quo_o
);

    logic [XLEN:0]   upper;
    logic [XLEN-1:0] diff;
    logic            ge;

    always_comb begin
        upper = {rem_i, quo_i[XLEN-1]};
        ge    = upper >= {1'b0, dvs_i};
        // When ge holds the true difference is below 2^XLEN, so the low bits suffice.
        diff  = upper[XLEN-1:0] - dvs_i;
        rem_o = ge ? diff : upper[XLEN-1:0];
        quo_o = {quo_i[XLEN-2:0], ge};
    end

endmodule

// File: rtl/divide.sv
// Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU; one op in flight, stalls via div_busy.
module divide
    import pcore_config_defs::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  type_exe2div_s exe2div_i,
    input  logic          div_flush_i,
    output type_div2wrb_s div2wrb_o,
    output type_div2fwd_s div2fwd_o
);

    type_div_state_e state_q, state_d;
    type_alu_d_ops_e op_q, op_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0]  quo_q, quo_d;
    logic [XLEN-1:0]  rem_q, rem_d;
    logic [XLEN-1:0]  dvs_q, dvs_d;
    logic [XLEN-1:0]  result_q, result_d;
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;
    logic             done_q, done_d;

    logic [XLEN-1:0] step_rem, step_quo;
    logic            req, accept, in_signed, in_div, op_div;

    div_step u_div_step (
        .rem_i (rem_q),
        .quo_i (quo_q),
        .dvs_i (dvs_q),
        .rem_o (step_rem),
        .quo_o (step_quo)
    );

    always_comb begin
        req       = exe2div_i.alu_d_ops != ALU_D_OPS_NONE;
        accept    = (state_q == DIV_IDLE) && req && !div_flush_i;
        in_signed = (exe2div_i.alu_d_ops == ALU_D_OPS_DIV) ||
                    (exe2div_i.alu_d_ops == ALU_D_OPS_REM);
        in_div    = (exe2div_i.alu_d_ops == ALU_D_OPS_DIV) ||
                    (exe2div_i.alu_d_ops == ALU_D_OPS_DIVU);
        op_div    = (op_q == ALU_D_OPS_DIV) || (op_q == ALU_D_OPS_DIVU);

        state_d   = state_q;
        op_d      = op_q;
        cnt_d     = cnt_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        dvs_d     = dvs_q;
        result_d  = result_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        done_d    = 1'b0;

        if (div_flush_i) begin
            state_d = DIV_IDLE;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                DIV_IDLE: begin
                    if (accept) begin
                        op_d      = exe2div_i.alu_d_ops;
                        cnt_d     = CNT_W'(XLEN - 1);
                        rem_d     = '0;
                        neg_quo_d = in_signed & (exe2div_i.opr1[XLEN-1] ^ exe2div_i.opr2[XLEN-1]);
                        neg_rem_d = in_signed & exe2div_i.opr1[XLEN-1];
                        quo_d     = in_signed ? abs_val(exe2div_i.opr1) : exe2div_i.opr1;
                        dvs_d     = in_signed ? abs_val(exe2div_i.opr2) : exe2div_i.opr2;
                        if (exe2div_i.opr2 == '0) begin
                            state_d  = DIV_DONE;
                            done_d   = 1'b1;
                            result_d = in_div ? '1 : exe2div_i.opr1;
                        end else if (in_signed && (exe2div_i.opr1 == {1'b1, {(XLEN-1){1'b0}}})
                                     && (exe2div_i.opr2 == '1)) begin
                            state_d  = DIV_DONE;
                            done_d   = 1'b1;
                            result_d = in_div ? {1'b1, {(XLEN-1){1'b0}}} : '0;
                        end else begin
                            state_d = DIV_BUSY;
                        end
                    end
                end
                DIV_BUSY: begin
                    quo_d = step_quo;
                    rem_d = step_rem;
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == '0) begin
                        state_d  = DIV_DONE;
                        done_d   = 1'b1;
                        result_d = op_div ? (neg_quo_q ? (~step_quo + 1'b1) : step_quo)
                                          : (neg_rem_q ? (~step_rem + 1'b1) : step_rem);
                    end
                end
                DIV_DONE: state_d = DIV_IDLE;
                default:  state_d = DIV_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= DIV_IDLE;
            op_q      <= ALU_D_OPS_NONE;
            cnt_q     <= '0;
            quo_q     <= '0;
            rem_q     <= '0;
            dvs_q     <= '0;
            result_q  <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            cnt_q     <= cnt_d;
            quo_q     <= quo_d;
            rem_q     <= rem_d;
            dvs_q     <= dvs_d;
            result_q  <= result_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        div2wrb_o.alu_result = result_q;
        div2wrb_o.div_done   = done_q;
        // Stall asserts in the request cycle itself so execute holds its operands.
        div2fwd_o.div_busy   = rst_n && (accept || (state_q == DIV_BUSY));
    end

endmodule

// File: tb/tb_divide.sv
// Self-checking bench for divide: directed vector table, random ops vs arithmetic model,
// flush and mid-operation reset sequences.
module tb_divide;
    import pcore_config_defs::*;

    logic          clk = 1'b0;
    logic          rst_n;
    type_exe2div_s req;
    logic          flush;
    type_div2wrb_s wrb;
    type_div2fwd_s fwd;

    int checks = 0;
    int errors = 0;

    divide u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .exe2div_i   (req),
        .div_flush_i (flush),
        .div2wrb_o   (wrb),
        .div2fwd_o   (fwd)
    );

    always #5 clk = ~clk;

    typedef struct {
        type_alu_d_ops_e op;
        logic [31:0]     a;
        logic [31:0]     b;
        logic [31:0]     exp;
        int              lat;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_result(input type_alu_d_ops_e op, input logic [31:0] a,
                                               input logic [31:0] b);
        longint sa, sb, r;
        sa = $signed(a);
        sb = $signed(b);
        case (op)
            ALU_D_OPS_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            ALU_D_OPS_REMU: return (b == 0) ? a : a % b;
            ALU_D_OPS_DIV: begin
                if (b == 0) return 32'hFFFF_FFFF;
                r = sa / sb;
                return r[31:0];
            end
            ALU_D_OPS_REM: begin
                if (b == 0) return a;
                r = sa % sb;
                return r[31:0];
            end
            default: return 32'h0;
        endcase
    endfunction

    function automatic int ref_lat(input type_alu_d_ops_e op, input logic [31:0] a,
                                   input logic [31:0] b);
        if (b == 0) return 1;
        if ((op == ALU_D_OPS_DIV || op == ALU_D_OPS_REM) && a == 32'h8000_0000 &&
            b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    // Present one request in the cycle after the previous DONE, then track it to completion.
    task automatic run_op(input string name, input type_alu_d_ops_e op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int lat);
        int cyc;
        int busy_bad;
        bit seen;
        @(negedge clk);
        check({name, " idle_no_done"}, 32'(wrb.div_done), 32'd0);
        req.alu_d_ops = op;
        req.opr1      = a;
        req.opr2      = b;
        #1;
        check({name, " busy_on_request"}, 32'(fwd.div_busy), 32'd1);
        @(posedge clk);
        cyc      = 0;
        busy_bad = 0;
        seen     = 1'b0;
        while (!seen && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (wrb.div_done) begin
                seen = 1'b1;
                if (fwd.div_busy !== 1'b0) busy_bad++;
                req.alu_d_ops = ALU_D_OPS_NONE;
            end else if (fwd.div_busy !== 1'b1) begin
                busy_bad++;
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL %s timeout: no div_done in %0d cycles, expected cycle %0d",
                     name, cyc, lat);
            req.alu_d_ops = ALU_D_OPS_NONE;
        end else begin
            check({name, " latency"}, 32'(cyc), 32'(lat));
            check({name, " result"}, wrb.alu_result, exp);
            check({name, " busy_window"}, 32'(busy_bad), 32'd0);
        end
    endtask

    initial begin
        type_alu_d_ops_e op;
        logic [31:0] a, b;
        int done_cnt;

        vecs[0]  = '{ALU_D_OPS_DIVU, 32'd20,         32'd3,          32'h0000_0006, 33};
        vecs[1]  = '{ALU_D_OPS_REMU, 32'd20,         32'd3,          32'h0000_0002, 33};
        vecs[2]  = '{ALU_D_OPS_DIV,  32'hFFFF_FFEC,  32'd3,          32'hFFFF_FFFA, 33};
        vecs[3]  = '{ALU_D_OPS_REM,  32'hFFFF_FFEC,  32'd3,          32'hFFFF_FFFE, 33};
        vecs[4]  = '{ALU_D_OPS_REM,  32'd20,         32'hFFFF_FFFD,  32'h0000_0002, 33};
        vecs[5]  = '{ALU_D_OPS_DIVU, 32'h0000_1234,  32'd0,          32'hFFFF_FFFF, 1};
        vecs[6]  = '{ALU_D_OPS_REMU, 32'h0000_1234,  32'd0,          32'h0000_1234, 1};
        vecs[7]  = '{ALU_D_OPS_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000, 1};
        vecs[8]  = '{ALU_D_OPS_REM,  32'h8000_0000,  32'hFFFF_FFFF,  32'h0000_0000, 1};
        vecs[9]  = '{ALU_D_OPS_REM,  32'hFFFF_FFF9,  32'd0,          32'hFFFF_FFF9, 1};
        vecs[10] = '{ALU_D_OPS_DIVU, 32'h8000_0000,  32'hFFFF_FFFF,  32'h0000_0000, 33};
        vecs[11] = '{ALU_D_OPS_DIV,  32'h7FFF_FFFF,  32'hFFFF_FFFE,  32'hC000_0001, 33};

        rst_n         = 1'b0;
        flush         = 1'b0;
        req.alu_d_ops = ALU_D_OPS_DIVU;
        req.opr1      = 32'd20;
        req.opr2      = 32'd3;
        #12;
        check("reset result", wrb.alu_result, 32'd0);
        check("reset done", 32'(wrb.div_done), 32'd0);
        check("reset busy_gated", 32'(fwd.div_busy), 32'd0);
        req.alu_d_ops = ALU_D_OPS_NONE;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("idle busy_no_request", 32'(fwd.div_busy), 32'd0);

        foreach (vecs[i]) begin
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp,
                   vecs[i].lat);
        end

        for (int i = 0; i < 40; i++) begin
            op = type_alu_d_ops_e'($urandom_range(1, 4));
            a  = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: b = $urandom_range(1, 15);
                2: begin
                    a = 32'h8000_0000;
                    b = 32'hFFFF_FFFF;
                end
                3: b = 32'hFFFF_FFFF - $urandom_range(0, 3);
                4: begin
                    a = $urandom_range(0, 100);
                    b = $urandom;
                end
                default: b = $urandom;
            endcase
            run_op($sformatf("rand%0d", i), op, a, b, ref_result(op, a, b), ref_lat(op, a, b));
        end

        // Flush partway through BUSY: the op dies silently and the next one runs clean.
        @(negedge clk);
        req.alu_d_ops = ALU_D_OPS_DIVU;
        req.opr1      = 32'd100;
        req.opr2      = 32'd7;
        @(posedge clk);
        repeat (10) @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush         = 1'b0;
        req.alu_d_ops = ALU_D_OPS_NONE;
        #1;
        check("flush busy_low", 32'(fwd.div_busy), 32'd0);
        done_cnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (wrb.div_done) done_cnt++;
        end
        check("flush no_done", 32'(done_cnt), 32'd0);
        run_op("post_flush", ALU_D_OPS_DIVU, 32'd100, 32'd7, 32'h0000_000E, 33);

        // Reset mid-operation with the request still presented.
        @(negedge clk);
        req.alu_d_ops = ALU_D_OPS_DIV;
        req.opr1      = 32'hFFFF_0000;
        req.opr2      = 32'd9;
        @(posedge clk);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midreset result", wrb.alu_result, 32'd0);
        check("midreset done", 32'(wrb.div_done), 32'd0);
        check("midreset busy", 32'(fwd.div_busy), 32'd0);
        req.alu_d_ops = ALU_D_OPS_NONE;
        @(negedge clk);
        rst_n = 1'b1;
        done_cnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (wrb.div_done) done_cnt++;
        end
        check("midreset no_done", 32'(done_cnt), 32'd0);
        run_op("b2b_remu", ALU_D_OPS_REMU, 32'hFFFF_FFFF, 32'h10, 32'h0000_000F, 33);
        run_op("b2b_divu", ALU_D_OPS_DIVU, 32'hFFFF_FFFF, 32'h10, 32'h0FFF_FFFF, 33);

        @(negedge clk);
        check("final no_done", 32'(wrb.div_done), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/divide.md
Name: divide

Overview:
- Iterative radix-2 restoring divider for the RV32M divide/remainder instructions (DIV, DIVU, REM, REMU).
- Sits beside the execute stage and answers the execute-to-divider request interface.
- Accepts one operation at a time and stalls the pipeline through the forwarding unit while busy.
- Returns the quotient or remainder to writeback with a single-cycle valid pulse.

Parameters:
- XLEN, 32, operand and result width.
- CNT_W, 5, iteration counter width; equals log2(XLEN).

Ports:
- clk  in  1  pipeline clock.
- rst_n  in  1  asynchronous active-low reset.
- exe2div_i  in  type_exe2div_s  request: alu_d_ops, opr1 (dividend, XLEN), opr2 (divisor, XLEN).
- div_flush_i  in  1  kill in-flight operation (pipeline flush).
- div2wrb_o  out  type_div2wrb_s  result: alu_result (XLEN), div_done (1).
- div2fwd_o  out  type_div2fwd_s  div_busy (1), the stall request to forwarding/hazard logic.

Behaviour:
- Single clock domain, clk. Asynchronous active-low reset rst_n.
- Reset values:
  - state=IDLE; counter, quotient, remainder, divisor and op registers all 0.
  - alu_result=0, div_done=0.
  - div_busy=0 while rst_n=0.
- States: IDLE, BUSY, DONE.
- Request accepted when state=IDLE and alu_d_ops != ALU_D_OPS_NONE and div_flush_i=0.
- div_busy is combinational:
  - High in IDLE when a request is present (no flush).
  - High throughout BUSY.
  - Low in DONE and in IDLE with no request.
  - This holds the request stable at the execute stage until the result returns.
- On accept, at the capture edge:
  - Latch op.
  - Signed ops (DIV, REM): record neg_q = sign(opr1) XOR sign(opr2) and neg_r = sign(opr1); latch absolute values of the operands.
  - Unsigned ops: latch operands raw, neg_q = neg_r = 0.
  - Counter = XLEN-1.
- Special cases bypass BUSY and go IDLE->DONE with the result registered at the capture edge:
  - Divide by zero (opr2=0): DIV/DIVU -> 0xFFFFFFFF; REM/REMU -> opr1 unmodified.
  - Signed overflow (DIV/REM, opr1=0x80000000, opr2=0xFFFFFFFF): DIV -> 0x80000000; REM -> 0.
- Normal path, IDLE->BUSY. Each BUSY cycle performs one restoring step:
  - Shift {rem, quo} left by 1.
  - Trial-subtract the divisor from the upper part.
  - If no borrow, keep the difference and set quo[0]=1; else quo[0]=0.
  - Decrement the counter.
  - After the step with counter=0, go to DONE. BUSY therefore lasts exactly XLEN (32) cycles.
- DONE, one cycle: div_done=1 and alu_result is valid.
  - DIV/DIVU output quo, negated if neg_q.
  - REM/REMU output rem, negated if neg_r.
  - Then go to IDLE.
- Latency, counted from the capture edge:
  - Normal ops: div_done high in cycle 33 (1 + 32 iterations).
  - Special cases: div_done high in cycle 1.
- Back-to-back: a new request may be accepted on the cycle after DONE (IDLE). A request present during DONE is ignored.
- div_flush_i:
  - In any state, the next edge forces IDLE and clears the counter.
  - No div_done is produced for the killed op.
  - Flush in DONE suppresses nothing already output that cycle; it only prevents a new accept.
  - Flush together with a new request in IDLE means no accept.
- alu_result holds its last value when div_done=0. Consumers qualify it with div_done.
- Reset asserted mid-operation: immediate return to IDLE, all outputs to reset values, no result.

Decomposition:
- pcore_config_defs package:
  - type_alu_d_ops_e (NONE, DIV, DIVU, REM, REMU).
  - type_exe2div_s, type_div2wrb_s, type_div2fwd_s.
  - DIV_STATE enum.
- One natural sub-module: div_step, a combinational single-iteration shift/subtract taking {rem, quo, divisor} and returning the next {rem, quo}. This keeps the FSM file clean and lets the step be unit-tested.

Test Plan:
- DIVU 20/3 -> div_busy high 33 cycles; div_done in cycle 33 with alu_result=0x00000006. REMU 20/3 -> 0x00000002.
- DIV 0xFFFFFFEC(-20)/3 -> 0xFFFFFFFA(-6). REM -> 0xFFFFFFFE(-2). REM 20/0xFFFFFFFD(-3) -> 0x00000002.
- DIVU 0x1234/0 -> div_done in cycle 1, 0xFFFFFFFF. REMU 0x1234/0 -> 0x00001234.
- DIV 0x80000000/0xFFFFFFFF -> cycle 1, 0x80000000. REM with the same operands -> 0.
- Start DIVU 100/7, assert div_flush_i at BUSY cycle 10 -> IDLE next cycle, div_busy low, no div_done. Then DIVU 100/7 -> 0x0000000E.
- Deassert rst_n at BUSY cycle 5 -> all outputs 0 asynchronously. After release, REMU 0xFFFFFFFF/0x10 -> 0x0000000F, back-to-back with DIVU 0xFFFFFFFF/0x10 -> 0x0FFFFFFF.
